// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: turns the core's pc into a single outstanding
// imem request and holds the returned (or fault-substituted) word until retired.
module instr_fetch_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] core_pc,
  input  logic        instr_ack,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic        fetch_fault,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;

  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       r_state;
  logic [31:0]      r_instr;
  logic             r_valid;
  logic             r_fault;
  logic             r_req;
  logic [31:0]      r_addr;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_late;

  logic w_moved;
  logic w_timeout;

  assign w_moved   = (core_pc != r_pc);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

  assign instruction = r_instr;
  assign instr_valid = r_valid;
  assign fetch_fault = r_fault;
  assign imem_req    = r_req;
  assign imem_addr   = r_addr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_pc    <= '0;
      r_cnt   <= '0;
      r_late  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // A timed-out request may still answer; swallow it before issuing another.
          if (r_late) begin
            if (imem_rvalid) r_late <= 1'b0;
          end else begin
            r_pc   <= core_pc;
            r_addr <= {core_pc[31:2], 2'b00};
            if (core_pc[1:0] != 2'b00) begin
              r_instr <= '0;
              r_fault <= 1'b1;
              r_valid <= 1'b1;
              r_state <= HOLD;
            end else begin
              r_req   <= 1'b1;
              r_state <= REQ;
            end
          end
        end
        REQ: begin
          if (imem_gnt) begin
            r_req   <= 1'b0;
            r_cnt   <= '0;
            r_state <= WAIT;
          end else if (w_moved) begin
            r_req   <= 1'b0;
            r_state <= IDLE;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (imem_rvalid) begin
            if (w_moved) begin
              r_state <= IDLE;
            end else begin
              r_instr <= imem_err ? '0 : imem_rdata;
              r_fault <= imem_err;
              r_valid <= 1'b1;
              r_state <= HOLD;
            end
          end else if (w_moved) begin
            r_state <= DRAIN;
          end else if (w_timeout) begin
            r_instr <= '0;
            r_fault <= 1'b1;
            r_valid <= 1'b1;
            r_late  <= 1'b1;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (r_late && imem_rvalid) r_late <= 1'b0;
          if (instr_ack || w_moved) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        DRAIN: begin
          r_cnt <= r_cnt + 1'b1;
          if (imem_rvalid || w_timeout) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a transaction-level model checked every
// cycle, plus hand-computed latency/data expectations per scenario.
module tb_instr_fetch_unit;
  localparam int unsigned TO = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] core_pc;
  logic        instr_ack;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        fetch_fault;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;

  always #5 clock = ~clock;

  instr_fetch_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .core_pc(core_pc), .instr_ack(instr_ack),
    .instruction(instruction), .instr_valid(instr_valid), .fetch_fault(fetch_fault),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: fetch activity as independent flags (presenting / requesting /
  // awaiting wanted data / draining unwanted data); idle when none is set.
  logic        m_present, m_fault, m_req, m_inflight, m_drain, m_late;
  logic [31:0] m_word, m_addr, m_pc;
  int          m_age;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_present <= 0; m_fault <= 0; m_req <= 0; m_inflight <= 0;
      m_drain <= 0; m_late <= 0; m_word <= 0; m_addr <= 0; m_pc <= 0; m_age <= 0;
    end else if (m_present) begin
      if (m_late && imem_rvalid) m_late <= 0;
      if (instr_ack || core_pc != m_pc) m_present <= 0;
    end else if (m_req) begin
      if (imem_gnt) begin
        m_req <= 0; m_inflight <= 1; m_age <= 0;
      end else if (core_pc != m_pc) m_req <= 0;
    end else if (m_inflight) begin
      m_age <= m_age + 1;
      if (imem_rvalid) begin
        m_inflight <= 0;
        if (core_pc == m_pc) begin
          m_present <= 1; m_fault <= imem_err; m_word <= imem_err ? 32'h0 : imem_rdata;
        end
      end else if (core_pc != m_pc) begin
        m_inflight <= 0; m_drain <= 1;
      end else if (m_age == TO - 1) begin
        m_inflight <= 0; m_present <= 1; m_fault <= 1; m_word <= 0; m_late <= 1;
      end
    end else if (m_drain) begin
      m_age <= m_age + 1;
      if (imem_rvalid || m_age == TO - 1) m_drain <= 0;
    end else if (m_late) begin
      if (imem_rvalid) m_late <= 0;
    end else begin
      m_pc   <= core_pc;
      m_addr <= core_pc & 32'hFFFF_FFFC;
      if (core_pc % 4 != 0) begin
        m_present <= 1; m_fault <= 1; m_word <= 0;
      end else m_req <= 1;
    end
  end

  always begin
    @(posedge clock);
    #1;
    if (!reset) begin
      check("cyc_valid", instr_valid, m_present);
      check("cyc_req", imem_req, m_req);
      if (m_req) check("cyc_addr", imem_addr, m_addr);
      if (m_present) begin
        check("cyc_instr", instruction, m_word);
        check("cyc_fault", fetch_fault, m_fault);
      end
    end
  end

  // Memory responder knobs and bookkeeping.
  int          gnt_hold = 0, rsp_delay = 1, rsp_timer = 0;
  int          gnt_count = 0, gnt_cyc = 0, cyc = 0, req_cycles = 0;
  logic        rsp_drop = 0, force_late = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF, rsp_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h8000_0000: return 32'h0000_0013;
      32'h8000_0004: return 32'h0010_0093;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  task automatic cycle();
    @(negedge clock);
    cyc++;
    if (imem_req) req_cycles++;
    imem_rvalid = 0; imem_rdata = 0; imem_err = 0;
    if (force_late) begin
      imem_rvalid = 1; imem_rdata = 32'hBAD0_BAD0; force_late = 0;
    end else if (rsp_timer > 0) begin
      rsp_timer--;
      if (rsp_timer == 0 && !rsp_drop) begin
        imem_rvalid = 1;
        imem_err    = (rsp_addr == err_addr);
        imem_rdata  = imem_err ? 32'hDEAD_BEEF : mem_word(rsp_addr);
      end
    end
    imem_gnt = 0;
    if (imem_req) begin
      if (gnt_hold > 0) gnt_hold--;
      else begin
        imem_gnt = 1; rsp_timer = rsp_delay; rsp_addr = imem_addr;
        gnt_count++; gnt_cyc = cyc;
      end
    end
  endtask

  task automatic wait_valid(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      cycle();
      if (instr_valid) begin at = cyc; break; end
    end
    if (at < 0) check("wait_valid_bound", 32'd0, 32'd1);
  endtask

  task automatic wait_grant(input int max);
    int g0;
    bit got;
    g0 = gnt_count;
    got = 0;
    for (int i = 0; i < max; i++) begin
      cycle();
      if (gnt_count != g0) begin got = 1; break; end
    end
    if (!got) check("wait_grant_bound", 32'd0, 32'd1);
  endtask

  task automatic retire(input logic [31:0] next_pc, output int ack_cyc);
    ack_cyc = cyc;
    instr_ack = 1;
    cycle();
    instr_ack = 0;
    core_pc = next_pc;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int t, n, g0, r0;
    reset = 1; core_pc = 32'h8000_0000; instr_ack = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; imem_err = 0;
    repeat (3) @(negedge clock);
    check("rst_instr", instruction, 32'h0);
    check("rst_valid", instr_valid, 32'h0);
    check("rst_fault", fetch_fault, 32'h0);
    check("rst_req", imem_req, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    reset = 0;
    cyc = 0;

    // First fetch, zero-wait memory.
    cycle();
    check("s1_req_c1", imem_req, 32'h1);
    check("s1_addr_c1", imem_addr, 32'h8000_0000);
    cycle(); cycle();
    check("s1_valid_c3", instr_valid, 32'h1);
    check("s1_instr_c3", instruction, 32'h0000_0013);
    cycle(); cycle();
    check("s1_held", instr_valid, 32'h1);
    retire(32'h8000_0004, n);
    wait_valid(12, t);
    check("s1_ack_to_valid", t - n, 32'd4);
    check("s1_instr2", instruction, 32'h0010_0093);

    // Grant withheld for 5 cycles.
    gnt_hold = 5; g0 = gnt_count; r0 = req_cycles;
    retire(32'h8000_0008, n);
    wait_valid(20, t);
    check("s2_one_grant", gnt_count - g0, 32'd1);
    check("s2_req_cycles", req_cycles - r0, 32'd6);
    check("s2_gnt_to_valid", t - gnt_cyc, 32'd2);

    // Misaligned pc: fault without bus traffic.
    r0 = req_cycles;
    retire(32'h8000_0002, n);
    wait_valid(10, t);
    check("s3_lat", t - n, 32'd2);
    check("s3_fault", fetch_fault, 32'h1);
    check("s3_instr", instruction, 32'h0);
    check("s3_no_req", req_cycles - r0, 32'd0);

    // Redirect out of HOLD onto a pc whose response errors.
    err_addr = 32'h8000_0010;
    n = cyc;
    core_pc = 32'h8000_0010;
    wait_valid(12, t);
    check("s4_redirect_lat", t - n, 32'd4);
    check("s4_fault", fetch_fault, 32'h1);
    check("s4_instr", instruction, 32'h0);
    retire(32'h8000_0014, n);
    wait_valid(12, t);
    check("s4_next_fault", fetch_fault, 32'h0);
    check("s4_next_instr", instruction, 32'hDA5A_0014);

    // pc changes while waiting: stale data discarded, new fetch issued.
    rsp_delay = 3; g0 = gnt_count;
    retire(32'h8000_0020, n);
    wait_grant(10);
    cycle();
    core_pc = 32'h8000_0100;
    wait_valid(25, t);
    check("s5_instr", instruction, 32'hDA5A_0100);
    check("s5_grants", gnt_count - g0, 32'd2);
    check("s5_new_addr", rsp_addr, 32'h8000_0100);
    rsp_delay = 1;

    // No response: timeout fault, then a late response must be swallowed.
    rsp_drop = 1;
    retire(32'h8000_0200, n);
    wait_grant(10);
    wait_valid(20, t);
    check("s6_gnt_to_fault", t - gnt_cyc, TO + 1);
    check("s6_fault", fetch_fault, 32'h1);
    check("s6_instr", instruction, 32'h0);
    retire(32'h8000_0204, n);
    rsp_drop = 0;
    r0 = req_cycles;
    repeat (4) cycle();
    check("s6_no_req_before_late", req_cycles - r0, 32'd0);
    force_late = 1;
    wait_valid(12, t);
    check("s6_after_late_instr", instruction, 32'hDA5A_0204);
    check("s6_after_late_fault", fetch_fault, 32'h0);
    check("s6_after_late_addr", rsp_addr, 32'h8000_0204);

    retire(32'h8000_0208, n);
    repeat (2) cycle();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
